sfifo_packer: RTL
=================

Name: sfifo_packer

Overview:
- Width-upsizing stage placed directly downstream of sfifo.
- Consumes the sfifo sender stream one word of type T per handshake.
- Packs RATIO consecutive words into one wide word and emits it on a valid/ready stream.
- Optional flush emits a partially filled group, zero-padded, with a word count.

Parameters:
- T, logic[31:0], type of one inbound word; W = $bits(T).
- RATIO, 4, inbound words per outbound word; legal range 2..16.
- CW, $clog2(RATIO+1), width of sender_count.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- receiver_data  input  W  inbound word (from sfifo sender.data).
- receiver_valid  input  1  inbound word present.
- receiver_ready  output  1  packer accepts the inbound word this cycle.
- flush  input  1  level request: emit the current partial group; held by requester until accepted.
- sender_data  output  RATIO*W  packed word; word k occupies bits [k*W +: W], first-received word in the LSBs.
- sender_count  output  CW  number of valid words in sender_data, 1..RATIO.
- sender_valid  output  1  packed word present.
- sender_ready  input  1  downstream accepts the packed word.

Behaviour:
- Reset (synchronous, active-high, all state):
  - sender_valid=0, sender_data=0, sender_count=0.
  - Fill count=0, accumulation buffer=0.
  - Reset overrides any handshake in the same cycle; a partial group is discarded.
- Inbound handshake rules:
  - receiver_ready = !sender_valid || sender_ready (combinational; no dependence on receiver_valid).
  - accept = receiver_valid && receiver_ready.
  - On accept, receiver_data is written into buffer slot [fill].
- Outbound handshake rules:
  - out_fire = sender_valid && sender_ready.
  - On out_fire with no new load, sender_valid clears.
  - While sender_valid && !sender_ready, sender_data and sender_count are held stable.
- Group completion (accept && fill==RATIO-1):
  - Output register loads {receiver_data, buffer[RATIO-2:0]}, sender_count=RATIO, sender_valid=1.
  - fill returns to 0 and the buffer clears to 0 (next cycle).
- Flush:
  - Sampled only when receiver_ready=1.
  - If flush && (fill>0 || accept) and the group is not completing this cycle: output loads buffer plus the current word if accepted, unused slots 0; sender_count = fill + accept; sender_valid=1; fill=0; buffer cleared.
  - If flush coincides with a group completion: a normal full group is emitted; flush has no additional effect.
  - If flush with fill==0 and no accept: ignored; no output.
  - Flush with receiver_ready=0: no effect; the requester keeps it asserted.
- Latency and throughput:
  - Last word of a group accepted in cycle N gives sender_valid=1 in cycle N+1.
  - Sustained rate is 1 inbound word per cycle when sender_ready=1 continuously.
  - A new load in the same cycle as out_fire replaces the output register with sender_valid held at 1; no bubble.
- Backpressure: when sender_valid && !sender_ready, receiver_ready=0 and nothing is accepted, even with fill < RATIO-1.
- Data integrity: no word is dropped, duplicated or reordered; the buffer slots above fill are always 0.

Test Plan:
- Setup for all scenarios: T=logic[7:0], RATIO=4, reset for 2 cycles.
1. After reset: sender_valid=0, sender_data=0, sender_count=0, receiver_ready=1.
2. Send 8'h11,22,33,44 back-to-back with sender_ready=1:
   - Cycle after 8'h44: sender_data=32'h44332211, sender_count=4, sender_valid=1 for exactly 1 cycle.
3. Continuous stream 8'h01..8'h0C, sender_ready=1:
   - Outputs are 32'h04030201, 32'h08070605, 32'h0C0B0A09 on consecutive 4-cycle boundaries.
   - receiver_ready never drops.
4. Group 8'hA1..A4 complete, then sender_ready=0 for 5 cycles while 8'hB1 is offered:
   - sender_data holds 32'hA4A3A2A1 and receiver_ready=0 throughout.
   - On sender_ready=1, B1 is accepted in the same cycle as the output handshake.
5. Send 8'h55,66, then assert flush with no valid input:
   - Next cycle sender_data=32'h00006655, sender_count=2.
   - A subsequent flush with fill=0 produces no output.
6. Send 8'h77, then 8'h88 with flush in the same cycle:
   - Output 32'h00008877, count=2.
   - Separately: 3 words followed by a 4th word with flush gives count=4 and one output only.
   - Reset asserted with fill=3 gives no output, and the next group starts in slot 0.

Source files
------------

// File: rtl/sfifo_packer.sv
// sfifo_packer: width-upsizing stage placed after sfifo.
// Packs RATIO consecutive inbound words of type T into one wide word. The
// first word received sits in the LSBs. A flush request emits a partly
// filled group, zero-padded, with its word count.
//
// Ports:
//   clock          system clock; all state changes on the rising edge
//   reset          synchronous, active-high; clears all state
//   receiver_data  inbound word (sfifo sender.data)
//   receiver_valid inbound word present
//   receiver_ready packer accepts the inbound word this cycle
//   flush          level request to emit the current partial group
//   sender_data    packed word; word k at [k*W +: W]
//   sender_count   number of valid words in sender_data (1..RATIO)
//   sender_valid   packed word present
//   sender_ready   downstream accepts the packed word
module sfifo_packer #(
  parameter type         T     = logic [31:0],
  parameter int unsigned RATIO = 4,
  parameter int unsigned CW    = $clog2(RATIO + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  T                                receiver_data,
  input  logic                            receiver_valid,
  output logic                            receiver_ready,
  input  logic                            flush,
  output logic [RATIO*$bits(T)-1:0]       sender_data,
  output logic [CW-1:0]                   sender_count,
  output logic                            sender_valid,
  input  logic                            sender_ready
);

  localparam int unsigned W  = $bits(T);
  localparam int unsigned FW = $clog2(RATIO);

  // Only RATIO-1 slots are buffered; the last word of a group goes straight
  // into the output register.
  logic [(RATIO-1)*W-1:0] r_buf;
  logic [FW-1:0]          r_fill;
  logic [RATIO*W-1:0]     r_data;
  logic [CW-1:0]          r_count;
  logic                   r_valid;

  logic                   w_rx_ready;
  logic                   w_accept;
  logic                   w_complete;
  logic                   w_flush;
  logic [RATIO*W-1:0]     w_merged;

  assign w_rx_ready = !r_valid || sender_ready;
  assign w_accept   = receiver_valid && w_rx_ready;
  assign w_complete = w_accept && (r_fill == FW'(RATIO - 1));
  // A completing group takes priority; flush then has nothing left to add.
  assign w_flush    = flush && w_rx_ready && ((r_fill != '0) || w_accept)
                      && !w_complete;

  // Buffer plus the word arriving this cycle. Slots above fill are already
  // zero, so this is the correctly padded output for both load cases.
  always_comb begin
    w_merged = {{W{1'b0}}, r_buf};
    if (w_accept) begin
      w_merged[r_fill*W +: W] = receiver_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_complete || w_flush) begin
      r_data  <= w_merged;
      r_count <= w_complete ? CW'(RATIO) : (CW'(r_fill) + CW'(w_accept));
      r_valid <= 1'b1;
      r_fill  <= '0;
      r_buf   <= '0;
    end else begin
      if (w_accept) begin
        r_buf[r_fill*W +: W] <= receiver_data;
        r_fill               <= r_fill + FW'(1);
      end
      if (r_valid && sender_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign receiver_ready = w_rx_ready;
  assign sender_data    = r_data;
  assign sender_count   = r_count;
  assign sender_valid   = r_valid;

endmodule
